// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the snake game sequencer: game-state codes and the
// one-hot direction encoding {up,down,left,right}.
package game_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_OVER  = 3'd3,
        ST_WIN   = 3'd4
    } state_e;

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    function automatic logic [3:0] dirOpposite(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

endpackage

// File: rtl/game_sequencer_edge_detect.sv
// Rising-edge detector for an already-debounced, synchronous button level.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_level,
    output logic o_rise
);
    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/game_sequencer.sv
// Snake game sequencer: game-state FSM, step strobe with speed-ups, and
// buffered direction changes committed on the step strobe.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int TICK_CYCLES = 1500000,
    parameter int MIN_TICK    = 600000,
    parameter int SPEED_STEP  = 60000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_pb,
    input  logic [3:0] direction_pb,
    input  logic       goodColl,
    input  logic       badColl,
    input  logic       isGameComplete,
    output logic       sync,
    output logic       game_rst,
    output logic [3:0] dir,
    output logic [2:0] state,
    output logic [3:0] speed_lvl
);
    localparam int PW = $clog2(TICK_CYCLES + 1);
    localparam logic [PW-1:0] P_INIT = PW'(TICK_CYCLES);
    localparam logic [PW-1:0] P_MIN  = PW'(MIN_TICK);
    localparam logic [PW-1:0] P_STEP = PW'(SPEED_STEP);
    localparam logic [PW-1:0] P_ONE  = PW'(1);

    logic          w_modeEdge;
    logic [3:0]    w_dirEdge;
    logic [3:0]    w_validEdge;
    logic [3:0]    w_newPending;
    logic          w_start;
    logic          w_stay;
    logic          w_wrap;
    logic [PW-1:0] w_fasterPeriod;
    state_e        w_nextState;

    state_e        r_state;
    logic [PW-1:0] r_cnt;
    logic [PW-1:0] r_period;
    logic [PW-1:0] r_pendPeriod;
    logic [3:0]    r_speed;
    logic [3:0]    r_dir;
    logic [3:0]    r_pending;

    edge_detect u_modeEdge (
        .clk     (clk),
        .reset   (reset),
        .i_level (mode_pb),
        .o_rise  (w_modeEdge)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_dirEdge
        edge_detect u_dirEdge (
            .clk     (clk),
            .reset   (reset),
            .i_level (direction_pb[gi]),
            .o_rise  (w_dirEdge[gi])
        );
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (w_modeEdge) w_nextState = ST_RUN;
            ST_RUN: begin
                if (badColl)             w_nextState = ST_OVER;
                else if (isGameComplete) w_nextState = ST_WIN;
                else if (w_modeEdge)     w_nextState = ST_PAUSE;
            end
            ST_PAUSE: if (w_modeEdge) w_nextState = ST_RUN;
            ST_OVER,
            ST_WIN:   if (w_modeEdge) w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // The strobe only fires when the game stays in RUN, so leaving RUN never steps.
    assign w_start = (r_state == ST_IDLE) && w_modeEdge;
    assign w_stay  = (r_state == ST_RUN) && (w_nextState == ST_RUN);
    assign w_wrap  = w_stay && (r_cnt == r_period - P_ONE);

    assign sync      = w_wrap && !reset;
    assign game_rst  = w_start && !reset;
    assign dir       = r_dir;
    assign state     = r_state;
    assign speed_lvl = r_speed;

    assign w_fasterPeriod = (r_pendPeriod >= P_MIN && (r_pendPeriod - P_MIN) >= P_STEP)
                          ? r_pendPeriod - P_STEP : P_MIN;

    // Reversals against either the committed or the queued heading are dropped.
    assign w_validEdge = w_dirEdge & ~dirOpposite(r_dir) & ~dirOpposite(r_pending);

    always_comb begin
        w_newPending = r_pending;
        if (w_validEdge[3])      w_newPending = DIR_UP;
        else if (w_validEdge[2]) w_newPending = DIR_DOWN;
        else if (w_validEdge[1]) w_newPending = DIR_LEFT;
        else if (w_validEdge[0]) w_newPending = DIR_RIGHT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_period     <= P_INIT;
            r_pendPeriod <= P_INIT;
            r_speed      <= '0;
            r_dir        <= DIR_RIGHT;
            r_pending    <= DIR_RIGHT;
        end else if (w_start) begin
            r_state      <= ST_RUN;
            r_cnt        <= '0;
            r_period     <= P_INIT;
            r_pendPeriod <= P_INIT;
            r_speed      <= '0;
            r_dir        <= DIR_RIGHT;
            r_pending    <= DIR_RIGHT;
        end else begin
            r_state   <= w_nextState;
            r_pending <= w_newPending;
            // A speed-up lands in r_pendPeriod and only reaches r_period on a wrap.
            if (w_wrap) begin
                r_cnt    <= '0;
                r_period <= r_pendPeriod;
                r_dir    <= r_pending;
            end else if (w_stay) begin
                r_cnt <= r_cnt + P_ONE;
            end
            if (r_state == ST_RUN && goodColl) begin
                r_pendPeriod <= w_fasterPeriod;
                if (r_speed != 4'hF) r_speed <= r_speed + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios plus a random run,
// all compared against a cycle-level behavioural model of the game rules.
module tb_game_sequencer;
    localparam int TICK = 8;
    localparam int MINT = 4;
    localparam int STEP = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode_pb = 1'b0;
    logic [3:0] direction_pb = 4'b0000;
    logic       goodColl = 1'b0;
    logic       badColl = 1'b0;
    logic       isGameComplete = 1'b0;
    logic       sync;
    logic       game_rst;
    logic [3:0] dir;
    logic [2:0] state;
    logic [3:0] speed_lvl;

    game_sequencer #(
        .TICK_CYCLES (TICK),
        .MIN_TICK    (MINT),
        .SPEED_STEP  (STEP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mode_pb        (mode_pb),
        .direction_pb   (direction_pb),
        .goodColl       (goodColl),
        .badColl        (badColl),
        .isGameComplete (isGameComplete),
        .sync           (sync),
        .game_rst       (game_rst),
        .dir            (dir),
        .state          (state),
        .speed_lvl      (speed_lvl)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: directions as indices 0=up 1=down 2=left 3=right, so the reverse is d^1.
    int       mState, mCount, mPeriod, mNextPeriod, mSpeed, mDir, mPend;
    bit       mPrevMode;
    bit [3:0] mPrevPress;

    logic [12:0] obsVec, expVec, lastObs, lastExp;
    int          drift = 0;

    function automatic logic [3:0] dirOnehot(input int d);
        return 4'(8 >> d);
    endfunction

    task automatic model_reset();
        mState = 0; mCount = 0; mPeriod = TICK; mNextPeriod = TICK;
        mSpeed = 0; mDir = 3; mPend = 3; mPrevMode = 0; mPrevPress = '0;
    endtask

    // Samples outputs at the falling edge, predicts them, then advances the model.
    task automatic run_cycle();
        bit modeEv, runStays, expSync, expRst;
        int newPend;
        @(negedge clk);
        modeEv   = mode_pb && !mPrevMode;
        runStays = (mState == 1) && !badColl && !isGameComplete && !modeEv;
        expSync  = !reset && runStays && (mCount == mPeriod - 1);
        expRst   = !reset && (mState == 0) && modeEv;
        expVec   = {expSync, expRst, 3'(mState), dirOnehot(mDir), 4'(mSpeed)};
        obsVec   = {sync, game_rst, state, dir, speed_lvl};
        if (obsVec !== expVec) begin
            drift++; lastObs = obsVec; lastExp = expVec;
        end
        if (reset) begin
            model_reset();
        end else begin
            newPend = mPend;
            for (int d = 3; d >= 0; d--)
                if (direction_pb[3-d] && !mPrevPress[d] && d != (mDir ^ 1) && d != (mPend ^ 1))
                    newPend = d;
            for (int d = 0; d < 4; d++) mPrevPress[d] = direction_pb[3-d];
            mPrevMode = mode_pb;
            if (mState == 0 && modeEv) begin
                mState = 1; mCount = 0; mPeriod = TICK; mNextPeriod = TICK;
                mSpeed = 0; mDir = 3; mPend = 3;
            end else begin
                if (expSync) begin
                    mCount = 0; mPeriod = mNextPeriod; mDir = mPend;
                end else if (runStays) begin
                    mCount++;
                end
                mPend = newPend;
                if (mState == 1 && goodColl) begin
                    mNextPeriod = (mNextPeriod - STEP < MINT) ? MINT : mNextPeriod - STEP;
                    if (mSpeed < 15) mSpeed++;
                end
                case (mState)
                    1: if (badColl) mState = 3; else if (isGameComplete) mState = 4;
                       else if (modeEv) mState = 2;
                    2: if (modeEv) mState = 1;
                    3, 4: if (modeEv) mState = 0;
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Returns the number of cycles up to and including the next sync, or 0 if none in 32.
    task automatic cycles_to_sync(output int n);
        n = 0;
        for (int i = 1; i <= 32 && n == 0; i++) begin
            run_cycle();
            if (obsVec[12] === 1'b1) n = i;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run_cycle();
        run_cycle();
        drift = 0;
        direction_pb = 4'($urandom); goodColl = 1'b1; mode_pb = 1'b1;
        run_cycle();
        total++;
        if (obsVec !== expVec) begin
            bad++; $display("[TB] FAIL reset_hold: got %h expected %h", obsVec, expVec);
        end
        direction_pb = '0; goodColl = 1'b0; mode_pb = 1'b0;
        run_cycle();
        reset = 1'b0;
        run_cycle();
        total++;
        if (obsVec !== 13'b0_0_000_0001_0000) begin
            bad++; $display("[TB] FAIL reset_state: got %h expected %h", obsVec, 13'b0_0_000_0001_0000);
        end
        total++;
        if (drift != 0) begin
            bad++; $display("[TB] FAIL reset_tracking: %0d cycles, last got %h expected %h", drift, lastObs, lastExp);
        end
    endtask

    task automatic test_start();
        drift = 0;
        mode_pb = 1'b1;
        run_cycle();
        total++;
        if (obsVec[11:8] !== 4'b1_000) begin
            bad++; $display("[TB] FAIL start_pulse: got %b expected %b", obsVec[11:8], 4'b1_000);
        end
        for (int k = 1; k <= 24; k++) begin
            if (k == 3) mode_pb = 1'b0;
            run_cycle();
            if (k == 1) begin
                total++;
                if (obsVec[11:8] !== 4'b0_001) begin
                    bad++; $display("[TB] FAIL start_state: got %b expected %b", obsVec[11:8], 4'b0_001);
                end
            end
            total++;
            if (obsVec[12] !== 1'((k % 8) == 0)) begin
                bad++; $display("[TB] FAIL sync_cadence k=%0d: got %b expected %b", k, obsVec[12], (k % 8) == 0);
            end
        end
        total++;
        if (drift != 0) begin
            bad++; $display("[TB] FAIL start_tracking: %0d cycles, last got %h expected %h", drift, lastObs, lastExp);
        end
    endtask

    task automatic test_direction();
        int n;
        drift = 0;
        direction_pb = 4'b1000; run_cycle();
        direction_pb = 4'b0000; run_cycle();
        direction_pb = 4'b0100; run_cycle();
        direction_pb = 4'b0000; run_cycle();
        cycles_to_sync(n);
        run_cycle();
        total++;
        if (n == 0 || obsVec[7:4] !== 4'b1000) begin
            bad++; $display("[TB] FAIL dir_commit: sync after %0d, dir %b expected 1000", n, obsVec[7:4]);
        end
        cycles_to_sync(n);
        run_cycle();
        total++;
        if (n == 0 || obsVec[7:4] !== 4'b1000) begin
            bad++; $display("[TB] FAIL dir_reject_down: sync after %0d, dir %b expected 1000", n, obsVec[7:4]);
        end
        total++;
        if (drift != 0) begin
            bad++; $display("[TB] FAIL dir_tracking: %0d cycles, last got %h expected %h", drift, lastObs, lastExp);
        end
    endtask

    task automatic test_pause();
        int n;
        drift = 0;
        for (int i = 0; i < 20 && !(mState == 1 && mCount == 5); i++) run_cycle();
        total++;
        if (!(mState == 1 && mCount == 5)) begin
            bad++; $display("[TB] FAIL pause_align: state %0d count %0d expected 1 and 5", mState, mCount);
        end
        mode_pb = 1'b1; run_cycle();
        mode_pb = 1'b0;
        for (int i = 0; i < 20; i++) begin
            run_cycle();
            total++;
            if ({obsVec[12], obsVec[10:8]} !== 4'b0_010) begin
                bad++; $display("[TB] FAIL pause_hold: got sync/state %b expected 0010", {obsVec[12], obsVec[10:8]});
            end
        end
        mode_pb = 1'b1; run_cycle();
        mode_pb = 1'b0;
        cycles_to_sync(n);
        total++;
        if (n != 3) begin
            bad++; $display("[TB] FAIL resume_sync: got %0d cycles expected 3", n);
        end
        total++;
        if (drift != 0) begin
            bad++; $display("[TB] FAIL pause_tracking: %0d cycles, last got %h expected %h", drift, lastObs, lastExp);
        end
    endtask

    task automatic test_speedup();
        int n;
        int expPer[3] = '{6, 4, 4};
        drift = 0;
        cycles_to_sync(n);
        for (int i = 0; i < 3; i++) begin
            goodColl = 1'b1; run_cycle();
            goodColl = 1'b0;
            cycles_to_sync(n);
            cycles_to_sync(n);
            total++;
            if (n != expPer[i]) begin
                bad++; $display("[TB] FAIL speed_period%0d: got %0d cycles expected %0d", i, n, expPer[i]);
            end
        end
        total++;
        if (obsVec[3:0] !== 4'd3) begin
            bad++; $display("[TB] FAIL speed_lvl: got %0d expected 3", obsVec[3:0]);
        end
        total++;
        if (drift != 0) begin
            bad++; $display("[TB] FAIL speed_tracking: %0d cycles, last got %h expected %h", drift, lastObs, lastExp);
        end
    endtask

    task automatic test_collision();
        drift = 0;
        for (int i = 0; i < 20 && !(mState == 1 && mCount == mPeriod - 1); i++) run_cycle();
        badColl = 1'b1; isGameComplete = 1'b1;
        run_cycle();
        total++;
        if (obsVec[12] !== 1'b0) begin
            bad++; $display("[TB] FAIL leave_run_sync: got %b expected 0", obsVec[12]);
        end
        badColl = 1'b0; isGameComplete = 1'b0;
        run_cycle();
        total++;
        if (obsVec[10:8] !== 3'd3) begin
            bad++; $display("[TB] FAIL over_state: got %0d expected 3", obsVec[10:8]);
        end
        for (int i = 0; i < 10; i++) begin
            goodColl = 1'($urandom); badColl = 1'($urandom); isGameComplete = 1'($urandom);
            run_cycle();
            total++;
            if ({obsVec[12], obsVec[10:8]} !== 4'b0_011) begin
                bad++; $display("[TB] FAIL over_hold: got sync/state %b expected 0011", {obsVec[12], obsVec[10:8]});
            end
        end
        goodColl = 1'b0; badColl = 1'b0; isGameComplete = 1'b0;
        mode_pb = 1'b1; run_cycle();
        mode_pb = 1'b0; run_cycle();
        total++;
        if (obsVec[10:8] !== 3'd0) begin
            bad++; $display("[TB] FAIL over_to_idle: got %0d expected 0", obsVec[10:8]);
        end
        total++;
        if (drift != 0) begin
            bad++; $display("[TB] FAIL collision_tracking: %0d cycles, last got %h expected %h", drift, lastObs, lastExp);
        end
    endtask

    task automatic test_reset_before_sync();
        int n;
        drift = 0;
        mode_pb = 1'b1; run_cycle();
        mode_pb = 1'b0;
        direction_pb = 4'b1000; run_cycle();
        direction_pb = 4'b0000;
        cycles_to_sync(n);
        run_cycle();
        total++;
        if (obsVec[7:4] !== 4'b1000) begin
            bad++; $display("[TB] FAIL pre_reset_dir: got %b expected 1000", obsVec[7:4]);
        end
        for (int i = 0; i < 20 && !(mState == 1 && mCount == TICK - 2); i++) run_cycle();
        reset = 1'b1; run_cycle();
        reset = 1'b0; run_cycle();
        total++;
        if ({obsVec[12], obsVec[10:4]} !== 8'b0_000_0001) begin
            bad++; $display("[TB] FAIL reset_before_sync: got %b expected 00000001", {obsVec[12], obsVec[10:4]});
        end
        total++;
        if (drift != 0) begin
            bad++; $display("[TB] FAIL reset_sync_tracking: %0d cycles, last got %h expected %h", drift, lastObs, lastExp);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) mode_pb = ~mode_pb;
            if ($urandom_range(0, 5) == 0) direction_pb = 4'($urandom) & 4'($urandom);
            goodColl       = ($urandom_range(0, 9) == 0);
            badColl        = ($urandom_range(0, 149) == 0);
            isGameComplete = ($urandom_range(0, 249) == 0);
            reset          = ($urandom_range(0, 699) == 0);
            run_cycle();
            total++;
            if (obsVec !== expVec) begin
                bad++; $display("[TB] FAIL rand_cycle %0d: got %h expected %h", c, obsVec, expVec);
            end
        end
        reset = 1'b0; mode_pb = 1'b0; direction_pb = '0;
        goodColl = 1'b0; badColl = 1'b0; isGameComplete = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_direction();
        test_pause();
        test_speedup();
        test_collision();
        test_reset_before_sync();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 1500000, initial clock cycles per snake step (8 steps/s at 12 MHz).
REQ-002 SHALL have parameter MIN_TICK, default 600000, floor on the step period.
REQ-003 SHALL have parameter SPEED_STEP, default 60000, period reduction per good collision.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mode_pb  in  1  mode button level, already debounced and synchronous.
- direction_pb  in  4  {up,down,left,right} button levels, debounced.
- goodColl  in  1  head/apple collision pulse.
- badColl  in  1  head/body or head/border collision level.
- isGameComplete  in  1  score-complete level.
- sync  out  1  one-cycle snake step strobe.
- game_rst  out  1  one-cycle clear pulse to the body, apple and score blocks.
- dir  out  4  one-hot committed direction {up,down,left,right}.
- state  out  3  game state code.
- speed_lvl  out  4  number of speed-ups applied, saturating at 15.

Function
REQ-005 SHALL implement states IDLE=0, RUN=1, PAUSE=2, OVER=3, WIN=4; codes 5-7 SHALL never occur.
REQ-006 SHALL detect rising edges on mode_pb and on each direction_pb bit using registered previous values; level-held buttons SHALL produce one event only.
REQ-007 IDLE->RUN on a mode edge, with game_rst=1 for exactly that cycle; the step counter, period, speed_lvl, dir and pending direction SHALL reload their reset values on that same edge.
REQ-008 RUN->PAUSE and PAUSE->RUN on a mode edge; the step counter SHALL hold its value in PAUSE.
REQ-009 RUN->OVER when badColl=1; RUN->WIN when isGameComplete=1 and badColl=0.
- Priority in RUN: badColl > isGameComplete > mode edge.
REQ-010 OVER->IDLE and WIN->IDLE on a mode edge; collision inputs SHALL be ignored outside RUN.
REQ-011 The step counter SHALL count 0..period-1 in RUN only; sync=1 in the cycle it equals period-1, and it SHALL wrap to 0 in the next cycle.
REQ-012 sync SHALL be 0 in every state except RUN, and SHALL be 0 in the cycle RUN is left.
REQ-013 Each direction edge SHALL update a pending direction.
- Priority among simultaneous edges: up > down > left > right.
- An edge opposite to the committed dir SHALL be discarded.
REQ-014 The pending direction SHALL be copied to dir in the same cycle sync=1, so dir changes at most once per step.
REQ-015 On a goodColl pulse in RUN, period SHALL become max(period-SPEED_STEP, MIN_TICK).
- The new period takes effect at the next counter wrap.
- speed_lvl SHALL increment, saturating at 15.
REQ-016 period SHALL be held in ceil(log2(TICK_CYCLES+1)) bits with no underflow; if goodColl coincides with sync, the wrap SHALL use the old period.

Reset
REQ-017 While reset=1 at a clk edge, all registers SHALL load reset values: state=IDLE, sync=0, game_rst=0, dir=4'b0001 (right), pending=4'b0001, counter=0, period=TICK_CYCLES, speed_lvl=0, edge registers=0.
REQ-018 reset asserted mid-RUN SHALL suppress any sync or game_rst in the following cycle.

Structure
REQ-019 A shared package SHALL hold the state enum (3-bit) and the direction one-hot constants (DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT).
REQ-020 Rising-edge detection SHALL be a sub-module named edge_detect, instantiated 5 times.

Verification
Bench parameters: TICK_CYCLES=8, MIN_TICK=4, SPEED_STEP=2.
REQ-021 Reset, then mode edge -> game_rst pulse for 1 cycle, state=1, first sync 8 cycles after entry, then sync every 8 cycles.
REQ-022 Press up then down before the next sync, with dir=right -> dir=up at that sync; the down press is rejected at the following sync.
REQ-023 Three goodColl pulses -> period sequence 6, 4, 4; speed_lvl=3.
REQ-024 Mode edge at counter=5 -> PAUSE, no sync for 20 cycles; mode edge again -> next sync 3 cycles later.
REQ-025 badColl and isGameComplete in the same cycle -> state=3 (OVER), sync=0 thereafter; mode edge -> state=0.
REQ-026 reset asserted in the cycle before a sync is due -> no sync, state=0, dir=4'b0001.
